// File: rtl/jtag_shift_master.sv
// JTAG initiator: walks an external TAP through IR/DR scans, TAP reset and
// run-idle cycles under a valid/ready command port, returning captured TDO.
module jtag_shift_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [5:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  // Bit counter must reach 5 for the TLR sequence and MAX_LEN-1 for shifts.
  localparam int unsigned CW = (MAX_LEN > 8) ? $clog2(MAX_LEN) : 3;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StBoot, StIdle, StTlr, StPre, StShift, StPost, StRti, StDone
  } st_e;

  st_e               st_q;
  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     div_q;
  logic [1:0]        op_q;
  logic [CW-1:0]     last_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap_q;
  logic              tck_q, tms_q, tdi_q, ready_q, rsp_valid_q;
  logic [MAX_LEN-1:0] rsp_data_q;

  logic [CW-1:0]     len_last;
  st_e               adv_st;
  logic [CW-1:0]     adv_cnt;
  logic              adv_end, adv_tms, adv_tdi;

  // TMS value for bit 'cnt' of phase 'st'.
  function automatic logic bit_tms(st_e st, logic [CW-1:0] cnt, logic ir, logic [CW-1:0] last);
    case (st)
      StBoot, StTlr: return cnt < CW'(5);
      StPre:         return (cnt == '0) || (ir && cnt == CW'(1));
      StShift:       return cnt == last;
      StPost:        return cnt == '0;
      default:       return 1'b0;
    endcase
  endfunction

  // Clamp requested length (0 or over MAX_LEN means MAX_LEN), stored as len-1.
  always_comb begin
    if (cmd_len_i == 6'd0 || 32'(cmd_len_i) > MAX_LEN) len_last = CW'(MAX_LEN - 1);
    else len_last = CW'(cmd_len_i - 6'd1);
  end

  // Phase/bit that follows the current bit, and the TMS/TDI it will drive.
  always_comb begin
    adv_st  = st_q;
    adv_cnt = cnt_q + 1'b1;
    adv_end = 1'b0;
    case (st_q)
      StBoot:  if (cnt_q == CW'(5)) begin adv_st = StIdle; adv_end = 1'b1; end
      StTlr:   if (cnt_q == CW'(5)) begin adv_st = StDone; adv_end = 1'b1; end
      StPre:   if (cnt_q == ((op_q == 2'b01) ? CW'(3) : CW'(2))) begin
                 adv_st  = StShift;
                 adv_cnt = '0;
               end
      StShift: if (cnt_q == last_q) begin adv_st = StPost; adv_cnt = '0; end
      StPost:  if (cnt_q == CW'(1)) begin adv_st = StDone; adv_end = 1'b1; end
      StRti:   if (cnt_q == last_q) begin adv_st = StDone; adv_end = 1'b1; end
      default: ;
    endcase
    adv_tms = bit_tms(adv_st, adv_cnt, op_q == 2'b01, last_q);
    adv_tdi = (adv_st == StShift) ? data_q[adv_cnt] : 1'b0;
  end

  // Command FSM and TCK engine; TMS/TDI set up at the start of each low phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q        <= StBoot;
      cnt_q       <= '0;
      div_q       <= '0;
      op_q        <= 2'b00;
      last_q      <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (st_q)
        StIdle: begin
          if (cmd_valid_i) begin
            ready_q <= 1'b0;
            op_q    <= cmd_op_i;
            last_q  <= len_last;
            data_q  <= cmd_data_i;
            cap_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            tdi_q   <= 1'b0;
            case (cmd_op_i)
              2'b00:   begin st_q <= StTlr; tms_q <= 1'b1; end
              2'b11:   begin st_q <= StRti; tms_q <= 1'b0; end
              default: begin st_q <= StPre; tms_q <= 1'b1; end
            endcase
          end
        end
        StDone: begin
          st_q    <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          if (div_q != DivLast) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!tck_q) begin
              tck_q <= 1'b1;
              if (st_q == StShift) cap_q[cnt_q] <= tdo_i;
            end else begin
              tck_q <= 1'b0;
              st_q  <= adv_st;
              cnt_q <= adv_cnt;
              if (!adv_end) begin
                tms_q <= adv_tms;
                tdi_q <= adv_tdi;
              end
              if (adv_st == StIdle) ready_q <= 1'b1;
              if (adv_st == StDone) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= (op_q == 2'b01 || op_q == 2'b10) ? cap_q : '0;
              end
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master with a behavioural TAP on the JTAG pins.
module tb_jtag_shift_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'b00;
  logic [5:0]  cmd_len_i = 6'd0;
  logic [31:0] cmd_data_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        busy_o, tck_o, tms_o, tdi_o, tdo_i;

  logic loop_en = 1'b0;
  logic tdo_val = 1'b0;
  assign tdo_i = loop_en ? tdi_o : tdo_val;

  jtag_shift_master #(.CLK_DIV(4), .MAX_LEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o),
    .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // TAP state encoding for the external-device model.
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                 UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

  int          tap_st = SHDR;
  logic [31:0] ir_sr = 32'd0;
  logic [31:0] ir_reg = 32'd0;
  int          tck_cnt = 0;
  logic        tms_log [1024];
  int          rsp_cnt = 0;
  int          acc_cnt = 0;

  // External TAP: log TMS per TCK rise, shift IR, advance the state.
  always @(posedge tck_o) begin
    tms_log[tck_cnt % 1024] = tms_o;
    tck_cnt = tck_cnt + 1;
    if (tap_st == SHIR) ir_sr = {tdi_o, ir_sr[31:1]};
    if (tap_st == UIR) ir_reg = ir_sr;
    case (tap_st)
      TLR:  tap_st = tms_o ? TLR  : RTI;
      RTI:  tap_st = tms_o ? SDR  : RTI;
      SDR:  tap_st = tms_o ? SIR  : CDR;
      CDR:  tap_st = tms_o ? E1DR : SHDR;
      SHDR: tap_st = tms_o ? E1DR : SHDR;
      E1DR: tap_st = tms_o ? UDR  : PDR;
      PDR:  tap_st = tms_o ? E2DR : PDR;
      E2DR: tap_st = tms_o ? UDR  : SHDR;
      UDR:  tap_st = tms_o ? SDR  : RTI;
      SIR:  tap_st = tms_o ? TLR  : CIR;
      CIR:  tap_st = tms_o ? E1IR : SHIR;
      SHIR: tap_st = tms_o ? E1IR : SHIR;
      E1IR: tap_st = tms_o ? UIR  : PIR;
      PIR:  tap_st = tms_o ? E2IR : PIR;
      E2IR: tap_st = tms_o ? UIR  : SHIR;
      default: tap_st = tms_o ? SDR : RTI;
    endcase
  end

  // Count response pulses and accepted commands.
  always @(posedge clk_i) begin
    if (rsp_valid_o === 1'b1) rsp_cnt = rsp_cnt + 1;
    if (cmd_valid_i && cmd_ready_o === 1'b1) acc_cnt = acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // TMS trace of n TCKs starting at index b, first TCK in the MSB.
  function automatic logic [63:0] trace(input int b, input int n);
    logic [63:0] acc = 64'd0;
    for (int i = 0; i < n; i++) acc = {acc[62:0], tms_log[(b + i) % 1024]};
    return acc;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 500) begin @(negedge clk_i); n++; end
    chk("ready_before_cmd", {63'd0, cmd_ready_o}, 64'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_len_i = len;
    cmd_data_i = data;
    @(negedge clk_i);
    // Scramble fields after accept: the DUT must not re-sample them.
    cmd_valid_i = 1'b0;
    cmd_op_i = 2'b00;
    cmd_len_i = 6'd0;
    cmd_data_i = 32'd0;
  endtask

  task automatic wait_rsp(input string tag, output logic [31:0] data);
    int n = 0;
    while (rsp_valid_o !== 1'b1 && n < 2000) begin @(negedge clk_i); n++; end
    chk({tag, "_rsp_seen"}, {63'd0, rsp_valid_o}, 64'd1);
    data = rsp_data_o;
    @(negedge clk_i);
    chk({tag, "_pulse_ready"}, {62'd0, rsp_valid_o, cmd_ready_o}, 64'b01);
  endtask

  task automatic wait_boot(input string tag, input int b);
    int c = 0;
    while (cmd_ready_o !== 1'b1 && c < 500) begin @(negedge clk_i); c++; end
    chk({tag, "_cycles"}, {63'd0, (c >= 48 && c <= 60)}, 64'd1);
    chk({tag, "_tcks"}, 64'(tck_cnt - b), 64'd6);
    chk({tag, "_tms"}, trace(b, 6), 64'h3E);
    chk({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
  endtask

  initial begin
    logic [31:0] d;
    int b, r, a, n;

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("rst_pins", {61'd0, tck_o, tms_o, tdi_o}, 64'b010);
    chk("rst_ready_busy", {62'd0, cmd_ready_o, busy_o}, 64'b01);
    chk("rst_rsp", {31'd0, rsp_valid_o, rsp_data_o}, 64'd0);

    // Boot TLR sequence
    rst_i = 1'b0;
    wait_boot("boot", 0);
    chk("boot_no_rsp", 64'(rsp_cnt), 64'd0);

    // DR loopback, len 8
    loop_en = 1'b1;
    b = tck_cnt; r = rsp_cnt;
    send_cmd(2'b10, 6'd8, 32'h0000_00A5);
    wait_rsp("dr8", d);
    chk("dr8_data", 64'(d), 64'hA5);
    chk("dr8_tcks", 64'(tck_cnt - b), 64'd13);
    chk("dr8_tms", trace(b, 13), 64'h1006);
    chk("dr8_one_rsp", 64'(rsp_cnt - r), 64'd1);
    chk("dr8_tap_rti", 64'(tap_st), 64'(RTI));

    // DR len 4 loopback: bits above len must be zero
    send_cmd(2'b10, 6'd4, 32'hFFFF_FFFF);
    wait_rsp("dr4", d);
    chk("dr4_data", 64'(d), 64'hF);

    // IR full width (len 0 -> 32), TDO held high
    loop_en = 1'b0; tdo_val = 1'b1;
    b = tck_cnt;
    send_cmd(2'b01, 6'd0, 32'hDEAD_BEEF);
    wait_rsp("ir32", d);
    chk("ir32_data", 64'(d), 64'hFFFF_FFFF);
    chk("ir32_tcks", 64'(tck_cnt - b), 64'd38);
    chk("ir32_tms", trace(b, 38), 64'h30_0000_0006);
    chk("ir32_model_ir", 64'(ir_reg), 64'hDEAD_BEEF);
    chk("ir32_tap_rti", 64'(tap_st), 64'(RTI));

    // Run-idle 3 with cmd_valid held while busy
    b = tck_cnt; a = acc_cnt;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 500) begin @(negedge clk_i); n++; end
    cmd_valid_i = 1'b1; cmd_op_i = 2'b11; cmd_len_i = 6'd3; cmd_data_i = 32'hFFFF_FFFF;
    n = 0;
    @(negedge clk_i);
    while (rsp_valid_o !== 1'b1 && n < 2000) begin @(negedge clk_i); n++; end
    cmd_valid_i = 1'b0;
    chk("rti3_rsp_seen", {63'd0, rsp_valid_o}, 64'd1);
    chk("rti3_data", 64'(rsp_data_o), 64'd0);
    chk("rti3_one_accept", 64'(acc_cnt - a), 64'd1);
    chk("rti3_tcks", 64'(tck_cnt - b), 64'd3);
    chk("rti3_tms", trace(b, 3), 64'd0);
    @(negedge clk_i);

    // Run-idle len 40 clamps to 32
    b = tck_cnt;
    send_cmd(2'b11, 6'd40, 32'd0);
    wait_rsp("rti40", d);
    chk("rti40_tcks", 64'(tck_cnt - b), 64'd32);

    // len 1 DR, TDO high
    b = tck_cnt;
    send_cmd(2'b10, 6'd1, 32'd1);
    wait_rsp("dr1", d);
    chk("dr1_data", 64'(d), 64'd1);
    chk("dr1_tcks", 64'(tck_cnt - b), 64'd6);
    chk("dr1_tms", trace(b, 6), 64'h26);

    // TAP reset command
    b = tck_cnt;
    send_cmd(2'b00, 6'd5, 32'hFFFF_FFFF);
    wait_rsp("tlr", d);
    chk("tlr_data", 64'(d), 64'd0);
    chk("tlr_tcks", 64'(tck_cnt - b), 64'd6);
    chk("tlr_tms", trace(b, 6), 64'h3E);
    chk("tlr_tap_rti", 64'(tap_st), 64'(RTI));

    // Reset during shift bit 7 of a 16-bit DR scan
    loop_en = 1'b1;
    b = tck_cnt; r = rsp_cnt;
    send_cmd(2'b10, 6'd16, 32'h0000_1234);
    n = 0;
    while ((tck_cnt - b) < 11 && n < 2000) begin @(negedge clk_i); n++; end
    chk("mid_reached_bit7", {63'd0, ((tck_cnt - b) == 11)}, 64'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_pins", {61'd0, tck_o, tms_o, tdi_o}, 64'b010);
    chk("mid_rst_ctrl", {61'd0, cmd_ready_o, busy_o, rsp_valid_o}, 64'b010);
    chk("mid_rst_data", 64'(rsp_data_o), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    b = tck_cnt;
    wait_boot("reboot", b);
    chk("mid_no_rsp", 64'(rsp_cnt - r), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
